// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
//   Multiplies with radix-2 shift-add and divides with restoring division.
//   Both work on operand magnitudes and fix the sign when the result is
//   written. Divide-by-zero and signed overflow skip the iterations and
//   finish in one cycle.
// Ports:
//   i_clk      sole clock, rising edge
//   i_rst      synchronous active-high reset; priority over everything else
//   i_start    request an operation; only accepted while idle
//   i_f3       RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   i_op_a     rs1 (multiplicand / dividend)
//   i_op_b     rs2 (multiplier / divisor)
//   i_flush    abort any in-flight operation; priority over i_start
//   o_busy     high while calculating or presenting the result
//   o_done     single-cycle result-valid pulse
//   o_result   result; holds its value until the next accepted start
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3_r;
  logic [XLEN-1:0]   opnd;    // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] acc;     // mul: {partial high, multiplier}; div: {rem, quotient}
  logic              neg_q;   // negate product / quotient
  logic              neg_r;   // negate remainder (dividend was negative)

  // ---- operand decode at accept ----
  logic              in_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   spec_res;

  always_comb begin
    in_div   = i_f3[2];
    // DIV/REM signed, DIVU/REMU unsigned; MUL/MULH both signed,
    // MULHSU only a signed, MULHU neither.
    a_sgn    = in_div ? ~i_f3[0] : (i_f3[1:0] != 2'b11);
    b_sgn    = in_div ? ~i_f3[0] : ~i_f3[1];
    a_neg    = a_sgn & i_op_a[XLEN-1];
    b_neg    = b_sgn & i_op_b[XLEN-1];
    mag_a    = a_neg ? (~i_op_a + 1'b1) : i_op_a;
    mag_b    = b_neg ? (~i_op_b + 1'b1) : i_op_b;
    div_zero = in_div & (i_op_b == '0);
    div_ovf  = in_div & ~i_f3[0]
             & (i_op_a == {1'b1, {(XLEN-1){1'b0}}})
             & (i_op_b == '1);
    // i_f3[1] selects the remainder forms
    spec_res = '0;
    if (div_zero)
      spec_res = i_f3[1] ? i_op_a : '1;
    else if (div_ovf)
      spec_res = i_f3[1] ? '0 : i_op_a;
  end

  // ---- one radix-2 step ----
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;

  always_comb begin
    // Add the multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole accumulator right (carry included).
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    // Shift the next dividend bit into the partial remainder and try to
    // subtract; a borrow means the subtraction is discarded (restore).
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (div_diff[XLEN])
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_next = f3_r[2] ? div_next : mul_next;
  end

  // ---- sign fix and result select after the last step ----
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod = neg_q ? (~acc_next + 1'b1) : acc_next;
    quo  = neg_q ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
    rem  = neg_r ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];
    if (f3_r[2])
      final_res = f3_r[1] ? rem : quo;
    else
      final_res = (f3_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // ---- control ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      f3_r     <= '0;
      opnd     <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state  <= IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            f3_r   <= i_f3;
            o_busy <= 1'b1;
            if (div_zero || div_ovf) begin
              o_result <= spec_res;
              o_done   <= 1'b1;
              state    <= DONE;
            end else begin
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= '0;
              if (in_div) begin
                opnd <= mag_b;
                acc  <= {{XLEN{1'b0}}, mag_a};
              end else begin
                opnd <= mag_a;
                acc  <= {{XLEN{1'b0}}, mag_b};
              end
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) begin
            o_result <= final_res;
            o_done   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values are even and >= 8.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_start  input  1  request to begin an operation.
REQ-005 SHALL have port i_f3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port i_op_a  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port i_op_b  input  XLEN  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port i_flush  input  1  abort any in-flight operation.
REQ-009 SHALL have port o_busy  output  1  high while state is CALC or DONE.
REQ-010 SHALL have port o_done  output  1  single-cycle result-valid pulse.
REQ-011 SHALL have port o_result  output  XLEN  operation result.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE.
REQ-013 SHALL accept i_start only in IDLE; i_f3, i_op_a and i_op_b are captured on the accepting edge; i_start in CALC or DONE is ignored.
REQ-014 SHALL, on accept with a normal operation, enter CALC, clear the iteration counter, and perform one radix-2 step per cycle for exactly XLEN cycles, then enter DONE.
REQ-015 SHALL be in DONE for exactly one cycle with o_done=1 and o_result valid, then return to IDLE; start-to-done latency is XLEN+1 cycles.
REQ-016 SHALL multiply by shift-add on operand magnitudes into a 2*XLEN product, then negate the product when exactly one signed operand is negative; signedness: MUL/MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned.
REQ-017 SHALL return the low XLEN product bits for MUL and the high XLEN bits for MULH, MULHSU and MULHU.
REQ-018 SHALL divide by restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned); the quotient is negated when operand signs differ, and the remainder takes the dividend's sign.
REQ-019 SHALL treat divide-by-zero (b=0, any div/rem op) as special: quotient all ones, remainder = i_op_a.
REQ-020 SHALL treat signed overflow (DIV/REM, a = 1 followed by XLEN-1 zeros, b = all ones) as special: quotient = a, remainder = 0.
REQ-021 SHALL route special cases from IDLE directly to DONE, skipping CALC, giving a latency of 1 cycle.
REQ-022 SHALL hold o_result stable from DONE until the next accepted start.
REQ-023 SHALL, when i_flush=1 in any state, enter IDLE on the next edge with o_done=0 and no o_result update; i_flush has priority over i_start in the same cycle.
REQ-024 SHALL keep o_done=0 in every cycle except DONE.

Reset
REQ-025 SHALL, when i_rst=1 at a rising edge (including mid-operation), enter IDLE and clear o_busy, o_done, o_result, the counter and all datapath registers to 0.
REQ-026 SHALL give i_rst priority over i_flush and i_start.

Verification (XLEN=32)
REQ-027 SHALL cover MUL a=7, b=0xFFFFFFFD -> o_result=0xFFFFFFEB, o_done exactly 33 cycles after accept, o_busy high for 33 cycles.
REQ-028 SHALL cover a=b=0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF, MUL 0x00000001.
REQ-029 SHALL cover a=0xFFFFFFF9 (-7), b=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF, DIVU 0x7FFFFFFC, REMU 0x00000001.
REQ-030 SHALL cover special cases: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; each with o_done 1 cycle after accept.
REQ-031 SHALL cover flush and start collision: i_flush at CALC cycle 10 -> o_busy=0 next cycle, no o_done, next start produces a correct result; i_start during CALC is ignored; i_flush and i_start together in IDLE -> stays IDLE.
REQ-032 SHALL cover reset mid-operation: i_rst at CALC cycle 5 -> all outputs 0 next cycle, then a fresh MUL 3*4 -> 0x0000000C.
